// File: rtl/fifo_uart_tx.sv
// Drains a first-word-fall-through FIFO into an asynchronous UART frame: start, LSB-first data, stop bit(s).
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state_reg, state_next;
    logic [BAUD_W-1:0]       baud_reg, baud_next;
    logic [BIT_W-1:0]        bit_reg, bit_next;
    logic                    stop_reg, stop_next;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
    logic                    tx_reg, tx_next;
    logic                    done_reg, done_next;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                    parity_reg, parity_next;
`endif

    logic bit_end;
    logic last_stop;
    logic pop;

    assign bit_end   = (baud_reg == BAUD_LAST);
    assign last_stop = (state_reg == STOP) && bit_end && (stop_reg == STOP_LAST);
    // A pop in the final stop cycle chains the next start bit with no idle gap.
    assign pop       = enable && !fifo_empty && ((state_reg == IDLE) || last_stop) && !reset;

    assign fifo_read_en = pop;
    assign tx           = tx_reg;
    assign busy         = (state_reg != IDLE);
    assign frame_done   = done_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            stop_reg   <= 1'b0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
            done_reg   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            stop_reg   <= stop_next;
            shift_reg  <= shift_next;
            tx_reg     <= tx_next;
            done_reg   <= done_next;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        baud_next   = ((state_reg == IDLE) || bit_end) ? '0 : baud_reg + 1'b1;
        bit_next    = bit_reg;
        stop_next   = stop_reg;
        shift_next  = shift_reg;
        tx_next     = tx_reg;
        done_next   = last_stop;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif

        case (state_reg)
            IDLE: tx_next = 1'b1;
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    bit_next   = '0;
                    tx_next    = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_reg == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = parity_reg;
`else
                        state_next = STOP;
                        stop_next  = 1'b0;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_next = bit_reg + 1'b1;
                        tx_next  = shift_next[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    stop_next  = 1'b0;
                    tx_next    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_reg == STOP_LAST) begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end else begin
                        stop_next = stop_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // A pop overrides the stop/idle transition and loads the next word.
        if (pop) begin
            state_next  = START;
            baud_next   = '0;
            shift_next  = fifo_data;
            tx_next     = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_next = ^fifo_data;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: the bench acts as the FIFO and predicts every tx cycle of each popped word.
// Build with FIFO_UART_TX_PARITY_EN defined to also exercise the parity frames.
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int SB  = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_read_en;
    logic          tx;
    logic          busy;
    logic          frame_done;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_read_en(fifo_read_en), .tx(tx),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic tx;
        logic last;
    } ent_t;

    logic [DW-1:0] fifo_q[$];
    ent_t          sb_q[$];
    logic          fd_exp = 1'b0;
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic update_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push_bits(input logic b, input logic last_bit);
        for (int k = 0; k < CPB; k++) begin
            ent_t e;
            e.tx   = b;
            e.last = last_bit && (k == CPB - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic push_frame(input logic [DW-1:0] w);
        push_bits(1'b0, 1'b0);
        for (int i = 0; i < DW; i++) push_bits(w[i], 1'b0);
`ifdef FIFO_UART_TX_PARITY_EN
        push_bits(^w, 1'b0);
`endif
        for (int s = 0; s < SB; s++) push_bits(1'b1, s == SB - 1);
    endtask

    // One clock cycle: compare at the falling edge, then advance past the rising edge.
    task automatic step();
        logic    exp_pop;
        logic    last_now;
        logic    rst_now;
        logic [DW-1:0] w;
        ent_t    e;
        @(negedge clk);
        cyc++;
        exp_pop = enable && (fifo_q.size() != 0) && (sb_q.size() <= 1) && !reset;
        check("fifo_read_en", fifo_read_en, exp_pop);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("tx", tx, e.tx);
            check("busy", busy, 1'b1);
            last_now = e.last;
        end else begin
            check("tx_idle", tx, 1'b1);
            check("busy_idle", busy, 1'b0);
            last_now = 1'b0;
        end
        check("frame_done", frame_done, fd_exp);
        fd_exp = last_now;
        if (exp_pop) begin
            w = fifo_q.pop_front();
            push_frame(w);
            $display("cycle %0d: pop word 0x%h", cyc, w);
        end
        rst_now = reset;
        @(posedge clk);
        #1;
        if (rst_now) begin
            sb_q.delete();
            fd_exp = 1'b0;
        end
        update_fifo();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        update_fifo();
        @(posedge clk);
        #1;
        // Reset held, then released with an empty FIFO.
        run(3);
        reset = 1'b0;
        run(5);

        // Single frame 0xA5.
        fifo_q.push_back(8'hA5);
        update_fifo();
        run(46);

        // Back-to-back 0x01, 0xFF.
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'hFF);
        update_fifo();
        run(90);

        // Empty FIFO for 100 cycles.
        run(100);

        // enable dropped mid-frame.
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'h99);
        update_fifo();
        run(10);
        enable = 1'b0;
        run(70);
        fifo_q.delete();
        update_fifo();
        enable = 1'b1;
        run(5);

        // Reset mid-frame, FIFO still non-empty on release.
        fifo_q.push_back(8'h55);
        fifo_q.push_back(8'h12);
        update_fifo();
        run(15);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(50);

`ifdef FIFO_UART_TX_PARITY_EN
        fifo_q.push_back(8'h07);
        update_fifo();
        run(50);
        fifo_q.push_back(8'h03);
        update_fifo();
        run(50);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
